// File: rtl/hack_soc_pkg.sv
// rtl/hack_soc_pkg.sv - shared ROM-load states and constants for the Hack SoC FPGA top level
package hack_soc_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        W_HI,
        W_LO,
        STROBE,
        RUN
    } load_state_t;

    localparam int ROM_WORD_WIDTH       = 16;
    localparam int DEFAULT_BYTE_TIMEOUT = 65535;

endpackage

// File: rtl/rx_byte_timeout.sv
// rtl/rx_byte_timeout.sv - inter-byte idle counter with clear/enable and a terminal-count pulse
module rx_byte_timeout
    import hack_soc_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_BYTE_TIMEOUT,
    parameter int WIDTH   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] count_q, count_d;

    // Fires on the TIMEOUT-th consecutive enabled cycle without a clear.
    assign expired_o = enable_i && !clear_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i || expired_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rom_load_ctrl.sv
// rtl/uart_rom_load_ctrl.sv - UART-fed ROM loader sequencer; ROM_LOADER_ECHO_EN adds TX echo
module uart_rom_load_ctrl
    import hack_soc_pkg::*;
#(
    parameter int DATA_WIDTH   = ROM_WORD_WIDTH,
    parameter int BYTE_TIMEOUT = DEFAULT_BYTE_TIMEOUT,
    parameter int TIMER_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    input  logic                  force_run,
    output logic                  rom_loader_load,
    output logic                  rom_loader_sck,
    output logic [DATA_WIDTH-1:0] rom_loader_data,
    input  logic                  rom_loader_ack,
    output logic                  hack_cpu_reset,
    output logic [7:0]            keycode,
    output logic                  loading,
    output logic                  load_error
);

    load_state_t           state_q, state_d;
    logic [7:0]            hi_q, hi_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sck_q, sck_d;
    logic [7:0]            keycode_q, keycode_d;
    logic                  load_error_q, load_error_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [7:0]            pend_byte_q, pend_byte_d;
    logic                  cpu_reset_q;
    logic                  timeout;

    // A byte parked during STROBE is served before any byte arriving live.
    logic       byte_avail;
    logic [7:0] in_byte;
    logic       aborting;
    assign byte_avail = pend_valid_q || rx_valid;
    assign in_byte    = pend_valid_q ? pend_byte_q : rx_byte;
    assign aborting   = force_run && (state_q != RUN);

    rx_byte_timeout #(
        .TIMEOUT (BYTE_TIMEOUT),
        .WIDTH   (TIMER_WIDTH)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (byte_avail || !(state_q == HDR_LO || state_q == W_LO)),
        .enable_i  (state_q == HDR_LO || state_q == W_LO),
        .expired_o (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HDR_HI;
            hi_q         <= '0;
            remaining_q  <= '0;
            data_q       <= '0;
            sck_q        <= 1'b0;
            keycode_q    <= '0;
            load_error_q <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_byte_q  <= '0;
            cpu_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            remaining_q  <= remaining_d;
            data_q       <= data_d;
            sck_q        <= sck_d;
            keycode_q    <= keycode_d;
            load_error_q <= load_error_d;
            pend_valid_q <= pend_valid_d;
            pend_byte_q  <= pend_byte_d;
            cpu_reset_q  <= rom_loader_load;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_HI: if (byte_avail) state_d = HDR_LO;
            HDR_LO: begin
                if (byte_avail)   state_d = ({hi_q, in_byte} == 16'd0) ? RUN : W_HI;
                else if (timeout) state_d = HDR_HI;
            end
            W_HI:   if (byte_avail) state_d = W_LO;
            W_LO: begin
                if (byte_avail)   state_d = STROBE;
                else if (timeout) state_d = W_HI;
            end
            STROBE: if (rom_loader_ack) state_d = (remaining_q == 16'd1) ? RUN : W_HI;
            default: state_d = RUN;
        endcase
        if (aborting) state_d = RUN;
    end

    always_comb begin
        hi_d         = hi_q;
        remaining_d  = remaining_q;
        data_d       = data_q;
        sck_d        = sck_q;
        keycode_d    = keycode_q;
        load_error_d = load_error_q;
        pend_valid_d = pend_valid_q;
        pend_byte_d  = pend_byte_q;

        if (state_q == STROBE) begin
            if (rx_valid) begin
                if (pend_valid_q) begin
                    load_error_d = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_byte_d  = rx_byte;
                end
            end
        end else begin
            // Pending byte is consumed now; a coinciding live byte takes its place.
            pend_valid_d = pend_valid_q && rx_valid;
            if (pend_valid_q && rx_valid) pend_byte_d = rx_byte;
        end

        case (state_q)
            HDR_HI, W_HI: if (byte_avail) hi_d = in_byte;
            HDR_LO: begin
                if (byte_avail)   remaining_d  = {hi_q, in_byte};
                else if (timeout) load_error_d = 1'b1;
            end
            W_LO: begin
                if (byte_avail) begin
                    data_d = DATA_WIDTH'({hi_q, in_byte});
                    sck_d  = 1'b1;
                end else if (timeout) begin
                    load_error_d = 1'b1;
                end
            end
            STROBE: begin
                if (rom_loader_ack) begin
                    sck_d       = 1'b0;
                    remaining_d = remaining_q - 16'd1;
                end
            end
            default: if (byte_avail) keycode_d = in_byte;
        endcase

        if (aborting) begin
            sck_d        = 1'b0;
            pend_valid_d = 1'b0;
        end
    end

    assign rom_loader_load = (state_q != RUN);
    assign loading         = (state_q != RUN);
    assign rom_loader_sck  = sck_q;
    assign rom_loader_data = data_q;
    assign hack_cpu_reset  = cpu_reset_q;
    assign keycode         = keycode_q;
    assign load_error      = load_error_q;

`ifdef ROM_LOADER_ECHO_EN
    logic       echo_req;
    logic [7:0] echo_new, echo_cand;
    logic       echo_pend_q;
    logic [7:0] echo_byte_q;
    logic       tx_start_q;
    logic [7:0] tx_byte_q;

    always_comb begin
        echo_req = 1'b0;
        echo_new = keycode_d;
        if (state_q == STROBE && rom_loader_ack && !force_run) begin
            echo_req = 1'b1;
            echo_new = {data_q[DATA_WIDTH-1 -: 4], data_q[3:0]};
        end else if (state_q == RUN && byte_avail) begin
            echo_req = 1'b1;
        end
    end

    // A newer echo replaces one still waiting for the transmitter.
    assign echo_cand = echo_req ? echo_new : echo_byte_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            echo_pend_q <= 1'b0;
            echo_byte_q <= '0;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= '0;
        end else begin
            tx_start_q <= 1'b0;
            if (echo_req || echo_pend_q) begin
                if (!tx_busy) begin
                    tx_start_q  <= 1'b1;
                    tx_byte_q   <= echo_cand;
                    echo_pend_q <= 1'b0;
                end else begin
                    echo_pend_q <= 1'b1;
                    echo_byte_q <= echo_cand;
                end
            end
        end
    end

    assign tx_start = tx_start_q;
    assign tx_byte  = tx_byte_q;
`else
    logic tx_busy_unused;
    assign tx_busy_unused = tx_busy;
    assign tx_start       = 1'b0;
    assign tx_byte        = '0;
`endif

endmodule
